// File: rtl/treeval_pkg.sv
// Shared widths, sequencer state/error enums and the node-record layout
// used by the treeval sequencer and its pass counter.
package treeval_pkg;

  localparam int W_ADDR         = 10;
  localparam int W_ACTION       = 3;
  localparam int W_REWARD       = 12;
  localparam int W_WEIGHT       = 7;
  localparam int MAX_DATA_WIDTH = 12;

  typedef enum logic [3:0] {
    S_IDLE,
    S_REC_WAIT,
    S_WR_W,
    S_WR_P,
    S_WR_R,
    S_WR_A,
    S_CONF,
    S_RESTART,
    S_SETTLE,
    S_DONE,
    S_ERR
  } seq_state_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_BAD_COUNT  = 2'd1,
    ERR_TIMEOUT    = 2'd2,
    ERR_BAD_PARENT = 2'd3
  } err_code_e;

  typedef struct packed {
    logic [W_ADDR-1:0]   parent;
    logic [W_ACTION-1:0] action;
    logic [W_REWARD-1:0] reward;
    logic [W_WEIGHT-1:0] weight;
  } node_rec_t;

endpackage

// File: rtl/treeval_pass_counter.sv
// Counts rising edges of treeval's exp_change level while enabled and runs a
// settle watchdog; settled/timeout are single-cycle pulses.
module treeval_pass_counter #(
  parameter int SETTLE_PASSES = 4,
  parameter int W_TIMEOUT     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic exp_change,
  output logic settled,
  output logic timeout
);

  localparam int W_CNT = $clog2(SETTLE_PASSES + 1);
  // Watchdog fires in the cycle whose increment would reach all-ones.
  localparam logic [W_TIMEOUT-1:0] WD_LAST = {{(W_TIMEOUT-1){1'b1}}, 1'b0};

  logic                 exp_q;
  logic                 rise;
  logic [W_CNT-1:0]     pass_cnt;
  logic [W_TIMEOUT-1:0] wd;

  assign rise = exp_change & ~exp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q    <= 1'b0;
      pass_cnt <= '0;
      wd       <= '0;
    end else begin
      exp_q <= exp_change;
      if (clear) begin
        pass_cnt <= '0;
        wd       <= '0;
      end else if (en) begin
        if (rise) pass_cnt <= pass_cnt + W_CNT'(1);
        wd <= wd + W_TIMEOUT'(1);
      end
    end
  end

  assign settled = en & rise & (pass_cnt == W_CNT'(SETTLE_PASSES - 1));
  assign timeout = en & (wd == WD_LAST);

endmodule

// File: rtl/treeval_seq.sv
// Treeval sideband sequencer: loads N node records as four field writes each,
// programs the node count, restarts treeval and latches the settled root result.
// Optional parent ordering check: define TREEVAL_SEQ_PARENT_CHECK_EN.
module treeval_seq
  import treeval_pkg::*;
#(
  parameter int SETTLE_PASSES = 4,
  parameter int W_TIMEOUT     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [W_ADDR-1:0]         start_nodes,
  output logic                      busy,
  input  logic                      node_valid,
  output logic                      node_ready,
  input  logic [W_ADDR-1:0]         node_parent,
  input  logic [W_ACTION-1:0]       node_action,
  input  logic [W_REWARD-1:0]       node_reward,
  input  logic [W_WEIGHT-1:0]       node_weight,
  output logic                      tv_rst,
  output logic                      tv_mem_weight,
  output logic                      tv_mem_par,
  output logic                      tv_mem_rew,
  output logic                      tv_mem_act,
  output logic [W_ADDR-1:0]         tv_mem_addr,
  output logic [MAX_DATA_WIDTH-1:0] tv_mem_data,
  output logic                      tv_conf_nodes,
  output logic [W_ADDR-1:0]         tv_conf_data,
  input  logic                      tv_exp_change,
  input  logic [W_REWARD-1:0]       tv_exp,
  input  logic [W_ACTION-1:0]       tv_act,
  output logic                      result_valid,
  input  logic                      result_ack,
  output logic [W_REWARD-1:0]       result_exp,
  output logic [W_ACTION-1:0]       result_act,
  output logic                      err,
  output logic [1:0]                err_code,
  input  logic                      err_clear,
  output seq_state_e                dbg_state
);

  seq_state_e        state;
  err_code_e         err_code_r;
  node_rec_t         rec;
  logic [W_ADDR-1:0] n_nodes;
  logic [W_ADDR-1:0] addr;
  logic              restart_q;
  logic              parent_bad;
  logic              settled;
  logic              timeout;

`ifdef TREEVAL_SEQ_PARENT_CHECK_EN
  // A non-root node must point at an address already written.
  assign parent_bad = (addr != '0) && (rec.parent >= addr);
`else
  assign parent_bad = 1'b0;
`endif

  treeval_pass_counter #(
    .SETTLE_PASSES(SETTLE_PASSES),
    .W_TIMEOUT    (W_TIMEOUT)
  ) u_pass_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (state == S_RESTART),
    .en        (state == S_SETTLE),
    .exp_change(tv_exp_change),
    .settled   (settled),
    .timeout   (timeout)
  );

  assign tv_rst    = rst | restart_q;
  assign err_code  = err_code_r;
  assign dbg_state = state;

  // Outputs are registered: each strobe is set on the transition into its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      err_code_r    <= ERR_NONE;
      rec           <= '0;
      n_nodes       <= '0;
      addr          <= '0;
      restart_q     <= 1'b0;
      busy          <= 1'b0;
      node_ready    <= 1'b0;
      tv_mem_weight <= 1'b0;
      tv_mem_par    <= 1'b0;
      tv_mem_rew    <= 1'b0;
      tv_mem_act    <= 1'b0;
      tv_mem_addr   <= '0;
      tv_mem_data   <= '0;
      tv_conf_nodes <= 1'b0;
      tv_conf_data  <= '0;
      result_valid  <= 1'b0;
      result_exp    <= '0;
      result_act    <= '0;
      err           <= 1'b0;
    end else begin
      tv_mem_weight <= 1'b0;
      tv_mem_par    <= 1'b0;
      tv_mem_rew    <= 1'b0;
      tv_mem_act    <= 1'b0;
      tv_conf_nodes <= 1'b0;
      restart_q     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (start_nodes < W_ADDR'(2)) begin
              err        <= 1'b1;
              err_code_r <= ERR_BAD_COUNT;
              state      <= S_ERR;
            end else begin
              n_nodes    <= start_nodes;
              addr       <= '0;
              busy       <= 1'b1;
              node_ready <= 1'b1;
              state      <= S_REC_WAIT;
            end
          end
        end
        S_REC_WAIT: begin
          if (node_valid) begin
            rec           <= '{parent: node_parent, action: node_action,
                               reward: node_reward, weight: node_weight};
            node_ready    <= 1'b0;
            tv_mem_weight <= 1'b1;
            tv_mem_addr   <= addr;
            tv_mem_data   <= {{(MAX_DATA_WIDTH-W_WEIGHT){1'b0}}, node_weight};
            state         <= S_WR_W;
          end
        end
        S_WR_W: begin
          state <= S_WR_P;
          if (!parent_bad) begin
            tv_mem_par  <= 1'b1;
            tv_mem_data <= {{(MAX_DATA_WIDTH-W_ADDR){1'b0}}, rec.parent};
          end
        end
        S_WR_P: begin
          if (parent_bad) begin
            busy       <= 1'b0;
            err        <= 1'b1;
            err_code_r <= ERR_BAD_PARENT;
            state      <= S_ERR;
          end else begin
            tv_mem_rew  <= 1'b1;
            tv_mem_data <= rec.reward;
            state       <= S_WR_R;
          end
        end
        S_WR_R: begin
          tv_mem_act  <= 1'b1;
          tv_mem_data <= {{(MAX_DATA_WIDTH-W_ACTION){1'b0}}, rec.action};
          state       <= S_WR_A;
        end
        S_WR_A: begin
          if (addr == n_nodes - W_ADDR'(1)) begin
            tv_conf_nodes <= 1'b1;
            tv_conf_data  <= n_nodes;
            state         <= S_CONF;
          end else begin
            addr       <= addr + W_ADDR'(1);
            node_ready <= 1'b1;
            state      <= S_REC_WAIT;
          end
        end
        S_CONF: begin
          restart_q <= 1'b1;
          state     <= S_RESTART;
        end
        S_RESTART: state <= S_SETTLE;
        S_SETTLE: begin
          // A pass edge landing on watchdog expiry still yields a result.
          if (settled) begin
            result_exp   <= tv_exp;
            result_act   <= tv_act;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= S_DONE;
          end else if (timeout) begin
            busy       <= 1'b0;
            err        <= 1'b1;
            err_code_r <= ERR_TIMEOUT;
            state      <= S_ERR;
          end
        end
        S_DONE: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            state        <= S_IDLE;
          end
        end
        S_ERR: begin
          if (err_clear) begin
            err        <= 1'b0;
            err_code_r <= ERR_NONE;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_treeval_seq.sv
// Directed bench for treeval_seq: field-write scoreboard, conf/restart pulses,
// settle/result handshake, bad count, timeout and (if enabled) parent check.
module tb_treeval_seq;
  import treeval_pkg::*;

  localparam int TB_W_TIMEOUT = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start;
  logic [W_ADDR-1:0]         start_nodes;
  logic                      busy;
  logic                      node_valid;
  logic                      node_ready;
  logic [W_ADDR-1:0]         node_parent;
  logic [W_ACTION-1:0]       node_action;
  logic [W_REWARD-1:0]       node_reward;
  logic [W_WEIGHT-1:0]       node_weight;
  logic                      tv_rst;
  logic                      tv_mem_weight, tv_mem_par, tv_mem_rew, tv_mem_act;
  logic [W_ADDR-1:0]         tv_mem_addr;
  logic [MAX_DATA_WIDTH-1:0] tv_mem_data;
  logic                      tv_conf_nodes;
  logic [W_ADDR-1:0]         tv_conf_data;
  logic                      tv_exp_change;
  logic [W_REWARD-1:0]       tv_exp;
  logic [W_ACTION-1:0]       tv_act;
  logic                      result_valid;
  logic                      result_ack;
  logic [W_REWARD-1:0]       result_exp;
  logic [W_ACTION-1:0]       result_act;
  logic                      err;
  logic [1:0]                err_code;
  logic                      err_clear;
  seq_state_e                dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int strobe_cnt = 0;
  int conf_cnt = 0;
  int rst_pulses = 0;
  logic [W_ADDR-1:0] conf_seen = '0;
  logic [23:0] exp_q[$];

  treeval_seq #(.SETTLE_PASSES(4), .W_TIMEOUT(TB_W_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .start_nodes(start_nodes), .busy(busy),
    .node_valid(node_valid), .node_ready(node_ready), .node_parent(node_parent),
    .node_action(node_action), .node_reward(node_reward), .node_weight(node_weight),
    .tv_rst(tv_rst), .tv_mem_weight(tv_mem_weight), .tv_mem_par(tv_mem_par),
    .tv_mem_rew(tv_mem_rew), .tv_mem_act(tv_mem_act), .tv_mem_addr(tv_mem_addr),
    .tv_mem_data(tv_mem_data), .tv_conf_nodes(tv_conf_nodes), .tv_conf_data(tv_conf_data),
    .tv_exp_change(tv_exp_change), .tv_exp(tv_exp), .tv_act(tv_act),
    .result_valid(result_valid), .result_ack(result_ack), .result_exp(result_exp),
    .result_act(result_act), .err(err), .err_code(err_code), .err_clear(err_clear),
    .dbg_state(dbg_state)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  // ---- comparison ----
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, expv);
    end
  endtask

  // ---- scoreboard: every field strobe and conf/restart pulse ----
  always @(negedge clk) begin
    logic [3:0]  s;
    logic [1:0]  kind;
    logic [23:0] got;
    if (!rst) begin
      s = {tv_mem_weight, tv_mem_par, tv_mem_rew, tv_mem_act};
      if (s != 4'b0) begin
        strobe_cnt++;
        chk("strobe_onehot", 32'($countones(s)), 32'd1);
        kind = tv_mem_weight ? 2'd0 : tv_mem_par ? 2'd1 : tv_mem_rew ? 2'd2 : 2'd3;
        got  = {kind, tv_mem_addr, tv_mem_data};
        chk("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("strobe_kind_addr_data", 32'(got), 32'(exp_q.pop_front()));
      end
      if (tv_conf_nodes) begin
        conf_cnt++;
        conf_seen = tv_conf_data;
      end
      if (tv_rst) rst_pulses++;
    end
  end

  // ---- driver tasks ----
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_state(input seq_state_e s, input int budget, input string tag);
    int n = 0;
    while (dbg_state !== s && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(dbg_state), 32'(s));
  endtask

  task automatic send_rec(input logic [W_ADDR-1:0] a_idx, input logic [W_ADDR-1:0] p,
                          input logic [W_ACTION-1:0] a, input logic [W_REWARD-1:0] r,
                          input logic [W_WEIGHT-1:0] w, input bit bad_parent);
    int n = 0;
    while (node_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("node_ready_wait", 32'(node_ready), 32'd1);
    exp_q.push_back({2'd0, a_idx, 5'b0, w});
    if (!bad_parent) begin
      exp_q.push_back({2'd1, a_idx, 2'b0, p});
      exp_q.push_back({2'd2, a_idx, r});
      exp_q.push_back({2'd3, a_idx, 9'b0, a});
    end
    node_valid  = 1'b1;
    node_parent = p;
    node_action = a;
    node_reward = r;
    node_weight = w;
    tick();
    node_valid = 1'b0;
  endtask

  task automatic do_start(input logic [W_ADDR-1:0] n);
    start       = 1'b1;
    start_nodes = n;
    tick();
    start = 1'b0;
  endtask

  task automatic do_err_clear();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);
    chk("err_code_cleared", 32'(err_code), 32'd0);
    chk("idle_after_clear", 32'(dbg_state), 32'(S_IDLE));
  endtask

  // ---- directed sequence ----
  initial begin
    int base_strobes;
    int base_rst;
    int n;
    rst = 1'b1; start = 1'b0; start_nodes = '0; node_valid = 1'b0;
    node_parent = '0; node_action = '0; node_reward = '0; node_weight = '0;
    tv_exp_change = 1'b0; tv_exp = '0; tv_act = '0; result_ack = 1'b0; err_clear = 1'b0;
    tick(); tick();
    chk("rst_tv_rst", 32'(tv_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_node_ready", 32'(node_ready), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_tv_mem_addr", 32'(tv_mem_addr), 32'd0);
    chk("rst_tv_conf_data", 32'(tv_conf_data), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_tv_rst", 32'(tv_rst), 32'd0);

    // Bad node count
    base_strobes = strobe_cnt;
    do_start(10'd1);
    chk("badcnt_err", 32'(err), 32'd1);
    chk("badcnt_code", 32'(err_code), 32'd1);
    chk("badcnt_busy", 32'(busy), 32'd0);
    tick();
    chk("badcnt_no_strobes", 32'(strobe_cnt), 32'(base_strobes));
    do_err_clear();

    // Reset in the middle of a load
    do_start(10'd3);
    chk("load_busy", 32'(busy), 32'd1);
    send_rec(10'd0, 10'd0, 3'd0, 12'd0, 7'd0, 1'b0);
    wait_state(S_REC_WAIT, 10, "midrst_rec_wait");
    rst = 1'b1;
    tick();
    chk("midrst_tv_rst", 32'(tv_rst), 32'd1);
    chk("midrst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_node_ready", 32'(node_ready), 32'd0);
    chk("midrst_mem_data", 32'(tv_mem_data), 32'd0);
    rst = 1'b0;
    tick();

    // Full three-node load with a host stall after the root record
    base_rst = rst_pulses;
    do_start(10'd3);
    send_rec(10'd0, 10'd0, 3'd0, 12'd0, 7'd0, 1'b0);
    wait_state(S_REC_WAIT, 10, "stall_rec_wait");
    base_strobes = strobe_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_node_ready", 32'(node_ready), 32'd1);
    end
    chk("stall_no_strobes", 32'(strobe_cnt), 32'(base_strobes));
    send_rec(10'd1, 10'd0, 3'd1, 12'h028, 7'd100, 1'b0);
    send_rec(10'd2, 10'd0, 3'd2, 12'hFEC, 7'd100, 1'b0);
    wait_state(S_SETTLE, 20, "load_settle");
    chk("load_all_writes", 32'(exp_q.size()), 32'd0);
    chk("load_conf_cnt", 32'(conf_cnt), 32'd1);
    chk("load_conf_data", 32'(conf_seen), 32'd3);
    chk("load_restart_pulses", 32'(rst_pulses - base_rst), 32'd1);

    // Four passes settle the result
    tv_exp = 12'd40;
    tv_act = 3'd1;
    for (int i = 0; i < 4; i++) begin
      tv_exp_change = 1'b1;
      tick(); tick();
      if (i < 3) chk("settle_not_yet", 32'(result_valid), 32'd0);
      tv_exp_change = 1'b0;
      tick(); tick();
    end
    chk("result_valid", 32'(result_valid), 32'd1);
    chk("result_exp", 32'(result_exp), 32'd40);
    chk("result_act", 32'(result_act), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    tv_exp = 12'd99;
    tv_act = 3'd5;
    tick(); tick(); tick();
    chk("result_held_exp", 32'(result_exp), 32'd40);
    chk("result_held_valid", 32'(result_valid), 32'd1);
    result_ack = 1'b1;
    start = 1'b1;
    start_nodes = 10'd5;
    tick();
    result_ack = 1'b0;
    start = 1'b0;
    chk("ack_result_valid", 32'(result_valid), 32'd0);
    chk("ack_idle", 32'(dbg_state), 32'(S_IDLE));
    tick();
    chk("ack_start_ignored", 32'(dbg_state), 32'(S_IDLE));

    // Settle watchdog with exp_change stuck low
    do_start(10'd2);
    send_rec(10'd0, 10'd0, 3'd3, 12'd7, 7'd0, 1'b0);
    send_rec(10'd1, 10'd0, 3'd4, 12'h800, 7'd50, 1'b0);
    wait_state(S_SETTLE, 20, "wd_settle");
    n = 0;
    while (dbg_state == S_SETTLE && n < 1000) begin
      tick();
      n++;
    end
    chk("wd_settle_cycles", 32'(n), 32'((1 << TB_W_TIMEOUT) - 1));
    chk("wd_err", 32'(err), 32'd1);
    chk("wd_code", 32'(err_code), 32'd2);
    chk("wd_writes", 32'(exp_q.size()), 32'd0);
    do_err_clear();

`ifdef TREEVAL_SEQ_PARENT_CHECK_EN
    // Forward parent reference aborts before the parent write
    do_start(10'd3);
    send_rec(10'd0, 10'd0, 3'd0, 12'd0, 7'd0, 1'b0);
    send_rec(10'd1, 10'd0, 3'd1, 12'd5, 7'd10, 1'b0);
    send_rec(10'd2, 10'd2, 3'd2, 12'd6, 7'd20, 1'b1);
    wait_state(S_ERR, 10, "parent_err_state");
    chk("parent_code", 32'(err_code), 32'd3);
    chk("parent_writes", 32'(exp_q.size()), 32'd0);
    chk("parent_busy", 32'(busy), 32'd0);
    do_err_clear();
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/treeval_seq.md
Name: treeval_seq

Overview:
- Sequencer that owns the treeval sideband interface: accepts node records from a host over valid/ready, serializes each into four treeval field writes, programs the node count, then restarts treeval.
- Counts completed evaluation passes and latches the settled root expectation and action into a result register with a valid/ack handshake.
- Sits between the host/DMA node feed and the treeval datapath; treeval itself is unchanged.

Parameters:
- W_ADDR, 10, node address width (max 1023 nodes via 10-bit conf_data)
- W_ACTION, 3, action field width
- W_REWARD, 12, signed reward width
- W_WEIGHT, 7, weight width (0-100)
- MAX_DATA_WIDTH, 12, treeval mem_data width
- SETTLE_PASSES, 4, exp_change rising edges to observe before the result is taken (must cover tree depth)
- W_TIMEOUT, 16, settle watchdog counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; begin a load of start_nodes records
- start_nodes  in  W_ADDR  node count N for this run
- busy  out  1  high from accepted start until DONE/ERR
- node_valid  in  1  host record valid
- node_ready  out  1  sequencer can take a record
- node_parent  in  W_ADDR  parent address of the record
- node_action  in  W_ACTION  action
- node_reward  in  W_REWARD  signed reward
- node_weight  in  W_WEIGHT  weight
- tv_rst  out  1  treeval reset (rst OR internal restart pulse)
- tv_mem_weight / tv_mem_par / tv_mem_rew / tv_mem_act  out  1 each  treeval field strobes
- tv_mem_addr  out  W_ADDR  target node
- tv_mem_data  out  MAX_DATA_WIDTH  field value, zero-extended
- tv_conf_nodes  out  1  node-count strobe
- tv_conf_data  out  W_ADDR  node count
- tv_exp_change  in  1  treeval pass indicator (level)
- tv_exp  in  W_REWARD  treeval root reward
- tv_act  in  W_ACTION  treeval root action
- result_valid  out  1  result held
- result_ack  in  1  host consumed result
- result_exp  out  W_REWARD  latched expectation
- result_act  out  W_ACTION  latched action
- err  out  1  sticky error
- err_code  out  2  0 none, 1 bad count, 2 timeout, 3 bad parent
- err_clear  in  1  clear err, return to IDLE

Behaviour:
- Reset: state IDLE. All strobes, node_ready, busy, result_valid, err = 0. result_exp, result_act, err_code, tv_mem_*, tv_conf_data = 0. tv_rst = 1 while rst.
- States: IDLE, REC_WAIT, WR_W, WR_P, WR_R, WR_A, CONF, RESTART, SETTLE, DONE, ERR.
- IDLE:
  - start with start_nodes in 2..1023: latch N, addr=0, -> REC_WAIT.
  - Otherwise start with start_nodes < 2: -> ERR, code 1.
  - start is ignored in every other state.
- REC_WAIT: node_ready=1. On node_valid&node_ready, capture the record -> WR_W.
- WR_W, WR_P, WR_R, WR_A: one cycle each, exactly one strobe high.
  - tv_mem_addr = addr.
  - data = weight, parent, reward (raw bits), action.
- After WR_A:
  - addr==N-1 -> CONF.
  - Otherwise addr+1 -> REC_WAIT.
  - Records map to addresses 0..N-1 in arrival order; root = address 0. The root's parent and weight fields are written but unused.
- CONF: tv_conf_nodes=1, tv_conf_data=N, one cycle -> RESTART.
- RESTART: tv_rst=1 for one cycle; clear the pass counter and watchdog -> SETTLE.
- SETTLE:
  - Register tv_exp_change; count rising edges.
  - On the SETTLE_PASSES-th edge, in the same cycle: result_exp<=tv_exp, result_act<=tv_act, result_valid<=1 -> DONE.
  - The watchdog increments each SETTLE cycle; at all-ones -> ERR, code 2.
  - An edge in the same cycle as watchdog saturation: the edge wins.
- DONE:
  - busy=0; result held stable.
  - result_ack -> result_valid=0, IDLE.
  - start in the same cycle as result_ack is ignored (one-cycle turnaround).
- ERR:
  - busy=0, err=1; code holds.
  - err_clear -> err=0, code 0, IDLE.
  - err_clear outside ERR is ignored.
- Reset mid-operation: abandons the load immediately. The partially written treeval contents are undefined; a new start rewrites all N records.
- Latency: 5 cycles per record minimum (1 handshake + 4 writes), then 2 cycles (CONF, RESTART), then settle time.

Optional Feature:
- TREEVAL_SEQ_PARENT_CHECK_EN
- Defined: in WR_P, a non-root record with parent >= addr aborts to ERR with code 3. No write strobe is issued that cycle.
- Undefined: parent is not checked; code 3 is never produced.

Decomposition:
- Shared package treeval_pkg holds:
  - width constants: W_ADDR, W_ACTION, W_REWARD, W_WEIGHT, MAX_DATA_WIDTH
  - sequencer state enum
  - err_code enum
  - the node-record struct (parent, action, reward, weight)
- One sub-module, treeval_pass_counter: edge detect on tv_exp_change, pass count, watchdog. Outputs are settled and timeout pulses.

Test Plan:
- Reset mid-REC_WAIT (after 1 record) -> all outputs return to reset values next cycle; tv_rst=1 during rst.
- start, start_nodes=3, records {p0,a0,r0,w0},{p0,a1,r40,w100},{p0,a2,r-20,w100} -> 12 strobes at addr 0,1,2 in W,P,R,A order; tv_conf_data=3; one tv_rst pulse.
- node_valid held low 10 cycles mid-load -> no strobes, node_ready stays 1, load resumes correctly.
- Treeval model raises 4 exp_change edges with tv_exp=40, tv_act=1 -> result_valid=1, result_exp=40, result_act=1; held until result_ack; then IDLE.
- start_nodes=1 -> err=1, err_code=1, no strobes; err_clear -> IDLE.
- tv_exp_change stuck low -> err_code=2 after 2^W_TIMEOUT-1 SETTLE cycles. With the macro defined, record 2 with parent=2 -> err_code=3 and no WR_P strobe.
